// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if: request, builder-handshake and statistics signals of the TX scheduler.
// master = scheduler side, slave = requesters plus frame builder.
interface eth_tx_sched_if #(
  parameter int CNT_W = 16
);
  logic             arp_rq_valid;
  logic [47:0]      arp_rq_mac;
  logic             ip_tx_req;
  logic             ip_tx_ack;
  logic             tx_start;
  logic             tx_sel;
  logic [47:0]      tx_dst_mac;
  logic             tx_done;
  logic             tx_busy;
  logic             arp_pending;
  logic             timeout_err;
  logic [CNT_W-1:0] arp_tx_cnt;
  logic [CNT_W-1:0] ip_tx_cnt;
  modport master (
    input  arp_rq_valid, arp_rq_mac, ip_tx_req, tx_done,
    output ip_tx_ack, tx_start, tx_sel, tx_dst_mac, tx_busy, arp_pending,
           timeout_err, arp_tx_cnt, ip_tx_cnt
  );
  modport slave (
    output arp_rq_valid, arp_rq_mac, ip_tx_req, tx_done,
    input  ip_tx_ack, tx_start, tx_sel, tx_dst_mac, tx_busy, arp_pending,
           timeout_err, arp_tx_cnt, ip_tx_cnt
  );
endinterface

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: round-robin ARP/IP scheduler for the GMII TX builder with done timeout and IFG.
// Define ETH_TX_SCHED_STATS_EN to build the per-type frame counters.
module eth_tx_sched #(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input logic            aclk,
  input logic            aresetn,
  eth_tx_sched_if.master bus
);
  localparam int CMAX = IFG_CYCLES > TIMEOUT_CYCLES ? IFG_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, IFG} state_t;
  state_t        state_q;
  logic [TW-1:0] cnt_q;
  logic          arp_pending_q, arp_pending_d;
  logic [47:0]   shadow_mac_q, dst_mac_q;
  logic          last_ip_q, sel_q, start_q, ack_q, busy_q, timeout_q;
  logic          grant_arp, grant_ip;
  assign grant_arp     = state_q == IDLE && arp_pending_q && (!bus.ip_tx_req || last_ip_q);
  assign grant_ip      = state_q == IDLE && !grant_arp && bus.ip_tx_req;
  // a new request in the grant cycle re-arms pending for a follow-up reply
  assign arp_pending_d = bus.arp_rq_valid | (arp_pending_q & ~grant_arp);
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      arp_pending_q <= 1'b0;
      shadow_mac_q  <= '0;
      dst_mac_q     <= '0;
      last_ip_q     <= 1'b1;
      sel_q         <= 1'b0;
      start_q       <= 1'b0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      start_q       <= 1'b0;
      ack_q         <= 1'b0;
      timeout_q     <= 1'b0;
      arp_pending_q <= arp_pending_d;
      if (bus.arp_rq_valid) shadow_mac_q <= bus.arp_rq_mac;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (grant_arp || grant_ip) begin
            state_q   <= START;
            start_q   <= 1'b1;
            ack_q     <= grant_ip;
            sel_q     <= grant_ip;
            last_ip_q <= grant_ip;
            busy_q    <= 1'b1;
            if (grant_arp) dst_mac_q <= shadow_mac_q;
          end
        end
        START: begin
          state_q <= WAIT_DONE;
          cnt_q   <= TW'(1);
        end
        WAIT_DONE: begin
          if (bus.tx_done) begin
            state_q <= IFG;
            cnt_q   <= '0;
          end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= IFG;
            cnt_q     <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        default: begin
          if (cnt_q == TW'(IFG_CYCLES - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
      endcase
    end
  end
  assign bus.tx_start    = start_q;
  assign bus.ip_tx_ack   = ack_q;
  assign bus.tx_sel      = sel_q;
  assign bus.tx_dst_mac  = dst_mac_q;
  assign bus.tx_busy     = busy_q;
  assign bus.arp_pending = arp_pending_q;
  assign bus.timeout_err = timeout_q;
`ifdef ETH_TX_SCHED_STATS_EN
  logic [CNT_W-1:0] arp_cnt_q, ip_cnt_q;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arp_cnt_q <= '0;
      ip_cnt_q  <= '0;
    end else begin
      arp_cnt_q <= arp_cnt_q + CNT_W'(grant_arp);
      ip_cnt_q  <= ip_cnt_q + CNT_W'(grant_ip);
    end
  end
  assign bus.arp_tx_cnt = arp_cnt_q;
  assign bus.ip_tx_cnt  = ip_cnt_q;
`else
  assign bus.arp_tx_cnt = '0;
  assign bus.ip_tx_cnt  = '0;
`endif
endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: directed scoreboard bench; expected starts are queued, a negedge monitor checks them.
module tb_eth_tx_sched;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;
  eth_tx_sched_if #(.CNT_W(16)) bif ();
  eth_tx_sched #(.IFG_CYCLES(12), .TIMEOUT_CYCLES(4096), .CNT_W(16)) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bif)
  );
  typedef struct packed {
    logic        sel;
    logic [47:0] mac;
  } exp_t;
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ack_cnt = 0;
  localparam logic [47:0] MAC_A = 48'h0200000000AA;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask
  always @(negedge aclk) begin
    if (aresetn && bif.ip_tx_ack) ack_cnt++;
    if (aresetn && bif.ip_tx_ack && !bif.tx_start) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_without_start: ip_tx_ack=1 tx_start=0");
    end
    if (aresetn && bif.tx_start) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_start: tx_sel=%0d with empty scoreboard", bif.tx_sel);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("start_tx_sel", 64'(bif.tx_sel), 64'(e.sel));
        chk("start_ip_ack", 64'(bif.ip_tx_ack), 64'(e.sel));
        if (!e.sel) chk("start_dst_mac", 64'(bif.tx_dst_mac), 64'(e.mac));
      end
    end
  end
  task automatic check_zero(input string tag);
    chk({tag, "_tx_start"}, 64'(bif.tx_start), 0);
    chk({tag, "_ip_tx_ack"}, 64'(bif.ip_tx_ack), 0);
    chk({tag, "_tx_sel"}, 64'(bif.tx_sel), 0);
    chk({tag, "_tx_dst_mac"}, 64'(bif.tx_dst_mac), 0);
    chk({tag, "_tx_busy"}, 64'(bif.tx_busy), 0);
    chk({tag, "_arp_pending"}, 64'(bif.arp_pending), 0);
    chk({tag, "_timeout_err"}, 64'(bif.timeout_err), 0);
    chk({tag, "_arp_tx_cnt"}, 64'(bif.arp_tx_cnt), 0);
    chk({tag, "_ip_tx_cnt"}, 64'(bif.ip_tx_cnt), 0);
  endtask
  task automatic do_reset;
    aresetn = 1'b0;
    bif.arp_rq_valid = 1'b0;
    bif.ip_tx_req = 1'b0;
    bif.tx_done = 1'b0;
    repeat (2) tick;
    check_zero("reset");
    aresetn = 1'b1;
    tick;
  endtask
  task automatic wait_start;
    int n = 0;
    while (!bif.tx_start && n < 300) begin
      tick;
      n++;
    end
    if (!bif.tx_start) chk("start_wait_expired", 64'(n), 0);
    if (bif.ip_tx_ack) bif.ip_tx_req = 1'b0;
  endtask
  task automatic run_frame(input int lat, input int n_mid, input logic [47:0] m1, input logic [47:0] m2);
    int n = 0;
    wait_start;
    for (int i = 0; i < lat - 1; i++) begin
      bif.arp_rq_valid = (n_mid >= 1 && i == 2) || (n_mid >= 2 && i == 4);
      bif.arp_rq_mac = (i == 4) ? m2 : m1;
      tick;
    end
    bif.arp_rq_valid = 1'b0;
    bif.tx_done = 1'b1;
    tick;
    bif.tx_done = 1'b0;
    while (bif.tx_busy && n < 100) begin
      tick;
      n++;
    end
    chk("ifg_length", 64'(n), 12);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, acks0;
    bif.arp_rq_valid = 1'b0;
    bif.arp_rq_mac = '0;
    bif.ip_tx_req = 1'b0;
    bif.tx_done = 1'b0;
    do_reset;
    // single ARP: pending one cycle, then start with latched MAC, IFG of 12 after done
    exp_q.push_back('{sel: 1'b0, mac: MAC_A});
    bif.arp_rq_valid = 1'b1;
    bif.arp_rq_mac = MAC_A;
    tick;
    bif.arp_rq_valid = 1'b0;
    bif.arp_rq_mac = 48'h0;
    chk("arp1_pending_set", 64'(bif.arp_pending), 1);
    chk("arp1_no_start_yet", 64'(bif.tx_start), 0);
    tick;
    chk("arp1_start", 64'(bif.tx_start), 1);
    chk("arp1_pending_clr", 64'(bif.arp_pending), 0);
    chk("arp1_busy", 64'(bif.tx_busy), 1);
    chk("arp1_dst", 64'(bif.tx_dst_mac), 64'(MAC_A));
    tick;
    chk("arp1_start_pulse", 64'(bif.tx_start), 0);
    repeat (27) tick;
    bif.tx_done = 1'b1;
    tick;
    bif.tx_done = 1'b0;
    repeat (11) tick;
    chk("arp1_busy_ifg_end", 64'(bif.tx_busy), 1);
    tick;
    chk("arp1_busy_low", 64'(bif.tx_busy), 0);
`ifdef ETH_TX_SCHED_STATS_EN
    chk("arp1_arp_cnt", 64'(bif.arp_tx_cnt), 1);
`else
    chk("arp1_arp_cnt", 64'(bif.arp_tx_cnt), 0);
`endif
    // contention after reset: ARP first, then IP, then the ARP pulsed mid-frame
    do_reset;
    acks0 = ack_cnt;
    exp_q.push_back('{sel: 1'b0, mac: 48'h0200000000A1});
    exp_q.push_back('{sel: 1'b1, mac: 48'h0});
    exp_q.push_back('{sel: 1'b0, mac: 48'h0200000000A3});
    bif.arp_rq_valid = 1'b1;
    bif.arp_rq_mac = 48'h0200000000A1;
    tick;
    bif.arp_rq_valid = 1'b0;
    bif.ip_tx_req = 1'b1;
    run_frame(20, 1, 48'h0200000000A3, 48'h0);
    run_frame(20, 0, 48'h0, 48'h0);
    run_frame(20, 0, 48'h0, 48'h0);
    chk("cont_ack_count", 64'(ack_cnt - acks0), 1);
    chk("cont_sb_empty", 64'(exp_q.size()), 0);
`ifdef ETH_TX_SCHED_STATS_EN
    chk("cont_arp_cnt", 64'(bif.arp_tx_cnt), 2);
    chk("cont_ip_cnt", 64'(bif.ip_tx_cnt), 1);
`else
    chk("cont_ip_cnt", 64'(bif.ip_tx_cnt), 0);
`endif
    // overwrite: two pulses during an IP frame yield one reply to the newer MAC
    exp_q.push_back('{sel: 1'b1, mac: 48'h0});
    exp_q.push_back('{sel: 1'b0, mac: 48'h020000000002});
    bif.ip_tx_req = 1'b1;
    run_frame(20, 2, 48'h020000000001, 48'h020000000002);
    chk("ovw_pending", 64'(bif.arp_pending), 1);
    run_frame(15, 0, 48'h0, 48'h0);
    chk("ovw_pending_clr", 64'(bif.arp_pending), 0);
    chk("ovw_sb_empty", 64'(exp_q.size()), 0);
    // timeout: no done, error exactly 4096 cycles after start, stray done in IFG ignored
    exp_q.push_back('{sel: 1'b1, mac: 48'h0});
    bif.ip_tx_req = 1'b1;
    wait_start;
    n = 0;
    while (!bif.timeout_err && n < 5000) begin
      tick;
      n++;
    end
    chk("tmo_latency", 64'(n), 4096);
    chk("tmo_busy", 64'(bif.tx_busy), 1);
    tick;
    chk("tmo_pulse_width", 64'(bif.timeout_err), 0);
    bif.tx_done = 1'b1;
    tick;
    bif.tx_done = 1'b0;
    n = 2;
    while (bif.tx_busy && n < 100) begin
      tick;
      n++;
    end
    chk("tmo_ifg_length", 64'(n), 12);
    repeat (5) tick;
    chk("tmo_idle_after", 64'(bif.tx_busy), 0);
    // set wins: request in the grant cycle keeps pending for a second reply
    exp_q.push_back('{sel: 1'b0, mac: 48'h0200000000B1});
    exp_q.push_back('{sel: 1'b0, mac: 48'h0200000000B2});
    bif.arp_rq_valid = 1'b1;
    bif.arp_rq_mac = 48'h0200000000B1;
    tick;
    bif.arp_rq_mac = 48'h0200000000B2;
    tick;
    bif.arp_rq_valid = 1'b0;
    chk("setw_start", 64'(bif.tx_start), 1);
    chk("setw_pending", 64'(bif.arp_pending), 1);
    run_frame(10, 0, 48'h0, 48'h0);
    run_frame(10, 0, 48'h0, 48'h0);
    chk("setw_pending_clr", 64'(bif.arp_pending), 0);
    chk("setw_sb_empty", 64'(exp_q.size()), 0);
    // reset mid-frame clears everything; the late done starts nothing
    exp_q.push_back('{sel: 1'b1, mac: 48'h0});
    bif.ip_tx_req = 1'b1;
    wait_start;
    repeat (3) tick;
    bif.arp_rq_valid = 1'b1;
    bif.arp_rq_mac = 48'h0200000000C1;
    tick;
    bif.arp_rq_valid = 1'b0;
    repeat (2) tick;
    chk("rst_mid_pending_before", 64'(bif.arp_pending), 1);
    aresetn = 1'b0;
    tick;
    check_zero("rst_mid");
    aresetn = 1'b1;
    bif.tx_done = 1'b1;
    tick;
    bif.tx_done = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bif.tx_busy || bif.tx_start || bif.timeout_err) n++;
      tick;
    end
    chk("rst_mid_stays_idle", 64'(n), 0);
    chk("final_sb_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
